// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache tag store.
// Holds the default geometry, the width helper functions and the
// per-way line-state record used by tag_mem_sa.
package cache_pkg;

    localparam int ADDR_W_DEF   = 14;
    localparam int OFFSET_W_DEF = 5;
    localparam int INDEX_W_DEF  = 2;
    localparam int WAYS_DEF     = 8;

    // Stored tags are held zero-extended to this width so the record type
    // does not depend on the instance geometry; unused upper bits are
    // constant zero and trim away in synthesis.
    localparam int TAG_MAX = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) begin
                r++;
            end
        end
        return r;
    endfunction

    function automatic int tag_w(input int addr_w, input int offset_w, input int index_w);
        return addr_w - offset_w - index_w;
    endfunction

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [TAG_MAX-1:0] tag;
    } line_t;

endpackage

// File: rtl/tag_lru_set.sv
// LRU age registers for one cache set.
// Ports:
//   clk, reset_n   clock and async active-low reset (age of way w resets to w)
//   touch, way     make 'way' most recent (age 0); younger ways age by one
//   victim_by_age  way whose age is WAYS-1 (least recently used)
module tag_lru_set
    import cache_pkg::*;
#(
    parameter int WAYS = WAYS_DEF,
    parameter int CH_W = clog2(WAYS_DEF)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            touch,
    input  logic [CH_W-1:0] way,
    output logic [CH_W-1:0] victim_by_age
);

    logic [CH_W-1:0] age [WAYS];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int w = 0; w < WAYS; w++) begin
                age[w] <= CH_W'(w);
            end
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (CH_W'(w) == way) begin
                    age[w] <= '0;
                end else if (age[w] < age[way]) begin
                    age[w] <= age[w] + 1'b1;
                end
            end
        end
    end

    // Ages form a permutation, so exactly one way matches.
    always_comb begin
        victim_by_age = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (age[w] == CH_W'(WAYS - 1)) begin
                victim_by_age = CH_W'(w);
            end
        end
    end

endmodule

// File: rtl/tag_mem_sa.sv
// Set-associative tag store: per way per set a tag, valid, dirty and LRU age.
// Lookup is combinational on the current state; state and the response
// registers update on the same edge, giving a one-cycle response.
// Ports:
//   clk, reset_n       clock and async active-low reset
//   req, addr          request valid and byte address
//   wr, md, inv        allocate on miss, mark dirty, invalidate on hit
//   resp_valid, hit    response valid (one cycle after req) and hit flag
//   chan               hit way or allocated victim way
//   tag_out, dirty_out tag / dirty of chan before this request's update
module tag_mem_sa
    import cache_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF,
    parameter int INDEX_W  = INDEX_W_DEF,
    parameter int WAYS     = WAYS_DEF,
    localparam int TAG_W   = tag_w(ADDR_W, OFFSET_W, INDEX_W),
    localparam int CH_W    = clog2(WAYS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              wr,
    input  logic              md,
    input  logic              inv,
    output logic              resp_valid,
    output logic              hit,
    output logic [CH_W-1:0]   chan,
    output logic [TAG_W-1:0]  tag_out,
    output logic              dirty_out
);

    localparam int SETS = 1 << INDEX_W;

    line_t              lines      [SETS][WAYS];
    logic [CH_W-1:0]    victim_age [SETS];

    logic [TAG_W-1:0]   tag_in;
    logic [INDEX_W-1:0] idx;
    logic               hit_any;
    logic [CH_W-1:0]    hit_way;
    logic               free_any;
    logic [CH_W-1:0]    free_way;
    logic [CH_W-1:0]    alloc_way;
    logic [CH_W-1:0]    touch_way;
    logic               do_touch;
    line_t              cur_line;

    logic unused_offset;
    logic unused_tag_hi;

    assign tag_in        = addr[ADDR_W-1 -: TAG_W];
    assign idx           = addr[OFFSET_W +: INDEX_W];
    assign unused_offset = ^addr[OFFSET_W-1:0];

    // Descending scans so the lowest matching / lowest free index wins.
    always_comb begin
        hit_any  = 1'b0;
        hit_way  = '0;
        free_any = 1'b0;
        free_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (lines[idx][w].valid && (lines[idx][w].tag == TAG_MAX'(tag_in))) begin
                hit_any = 1'b1;
                hit_way = CH_W'(w);
            end
            if (!lines[idx][w].valid) begin
                free_any = 1'b1;
                free_way = CH_W'(w);
            end
        end
    end

    assign alloc_way     = free_any ? free_way : victim_age[idx];
    assign touch_way     = hit_any ? hit_way : alloc_way;
    assign do_touch      = req && (hit_any ? !inv : wr);
    assign cur_line      = lines[idx][touch_way];
    assign unused_tag_hi = ^cur_line.tag[TAG_MAX-1:TAG_W];

    for (genvar s = 0; s < SETS; s++) begin : g_lru
        tag_lru_set #(
            .WAYS (WAYS),
            .CH_W (CH_W)
        ) u_lru (
            .clk           (clk),
            .reset_n       (reset_n),
            .touch         (do_touch && (idx == INDEX_W'(s))),
            .way           (touch_way),
            .victim_by_age (victim_age[s])
        );
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    lines[s][w] <= '0;
                end
            end
        end else if (req) begin
            if (hit_any) begin
                if (inv) begin
                    lines[idx][hit_way].valid <= 1'b0;
                    lines[idx][hit_way].dirty <= 1'b0;
                end else if (md) begin
                    lines[idx][hit_way].dirty <= 1'b1;
                end
            end else if (wr) begin
                lines[idx][alloc_way] <= '{valid: 1'b1, dirty: md, tag: TAG_MAX'(tag_in)};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            hit        <= 1'b0;
            chan       <= '0;
            tag_out    <= '0;
            dirty_out  <= 1'b0;
        end else begin
            resp_valid <= req;
            if (req) begin
                hit <= hit_any;
                if (hit_any || wr) begin
                    chan      <= touch_way;
                    tag_out   <= cur_line.tag[TAG_W-1:0];
                    // A hit line is valid, so this is its dirty bit; on
                    // allocation it flags a required writeback.
                    dirty_out <= cur_line.valid & cur_line.dirty;
                end else begin
                    chan      <= '0;
                    tag_out   <= '0;
                    dirty_out <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_tag_mem_sa.sv
module tb_tag_mem_sa;

    localparam int SETS = 4;
    localparam int WAYS = 8;

    logic        clk;
    logic        reset_n;
    logic        req;
    logic [13:0] addr;
    logic        wr;
    logic        md;
    logic        inv;
    logic        resp_valid;
    logic        hit;
    logic [2:0]  chan;
    logic [6:0]  tag_out;
    logic        dirty_out;

    tag_mem_sa dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .addr       (addr),
        .wr         (wr),
        .md         (md),
        .inv        (inv),
        .resp_valid (resp_valid),
        .hit        (hit),
        .chan       (chan),
        .tag_out    (tag_out),
        .dirty_out  (dirty_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       hit;
        logic [2:0] chan;
        logic [6:0] tag;
        logic       dirty;
        logic       tag_known;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: recency is kept as an ordered list (MRU first).
    bit m_valid [SETS][WAYS];
    bit m_dirty [SETS][WAYS];
    bit m_known [SETS][WAYS];
    int m_tag   [SETS][WAYS];
    int m_order [SETS][$];

    function automatic void model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_order[s].delete();
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_known[s][w] = 0;
                m_tag[s][w]   = 0;
                m_order[s].push_back(w);
            end
        end
    endfunction

    function automatic void model_touch(int s, int w);
        for (int i = 0; i < m_order[s].size(); i++) begin
            if (m_order[s][i] == w) begin
                m_order[s].delete(i);
                break;
            end
        end
        m_order[s].push_front(w);
    endfunction

    function automatic exp_t model_step(int t, int s, bit w_en, bit m_en, bit i_en);
        exp_t e;
        int   hw;
        int   v;
        hw = -1;
        e  = '{hit: 0, chan: 0, tag: 0, dirty: 0, tag_known: 1};
        for (int w = 0; w < WAYS; w++) begin
            if (hw < 0 && m_valid[s][w] && m_tag[s][w] == t) hw = w;
        end
        if (hw >= 0) begin
            e.hit   = 1;
            e.chan  = 3'(hw);
            e.tag   = 7'(m_tag[s][hw]);
            e.dirty = m_dirty[s][hw];
            if (i_en) begin
                m_valid[s][hw] = 0;
                m_dirty[s][hw] = 0;
            end else begin
                if (m_en) m_dirty[s][hw] = 1;
                model_touch(s, hw);
            end
        end else if (w_en) begin
            v = -1;
            for (int w = 0; w < WAYS; w++) begin
                if (v < 0 && !m_valid[s][w]) v = w;
            end
            if (v < 0) v = m_order[s][WAYS-1];
            e.chan      = 3'(v);
            e.tag       = 7'(m_tag[s][v]);
            e.tag_known = m_known[s][v];
            e.dirty     = m_valid[s][v] & m_dirty[s][v];
            m_valid[s][v] = 1;
            m_dirty[s][v] = m_en;
            m_tag[s][v]   = t;
            m_known[s][v] = 1;
            model_touch(s, v);
        end
        return e;
    endfunction

    task automatic issue(input int t, input int s, input int off, input bit w_en, input bit m_en, input bit i_en);
        @(negedge clk);
        #1;
        req  = 1'b1;
        addr = {t[6:0], s[1:0], off[4:0]};
        wr   = w_en;
        md   = m_en;
        inv  = i_en;
        sb.push_back(model_step(t, s, w_en, m_en, i_en));
    endtask

    task automatic idle();
        @(negedge clk);
        #1;
        req = 1'b0;
        wr  = 1'b0;
        md  = 1'b0;
        inv = 1'b0;
    endtask

    task automatic check_zero(input string name);
        tests++;
        if ({resp_valid, hit, chan, tag_out, dirty_out} !== 13'd0) begin
            fails++;
            $display("FAIL %s: outputs rv=%b hit=%b chan=%0d tag=%0h dirty=%b, required all 0",
                     name, resp_valid, hit, chan, tag_out, dirty_out);
        end
    endtask

    // Monitor: each response is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_resp: resp_valid=1 with no outstanding request");
                end else begin
                    e = sb.pop_front();
                    if (hit !== e.hit || chan !== e.chan || dirty_out !== e.dirty ||
                        (e.tag_known && tag_out !== e.tag)) begin
                        fails++;
                        $display("FAIL resp: got hit=%b chan=%0d tag=%0h dirty=%b, required hit=%b chan=%0d tag=%0h(known=%b) dirty=%b",
                                 hit, chan, tag_out, dirty_out, e.hit, e.chan, e.tag, e.tag_known, e.dirty);
                    end
                end
            end else if (sb.size() != 0) begin
                tests++;
                fails++;
                void'(sb.pop_front());
                $display("FAIL missing_resp: resp_valid=0, required 1");
            end
        end
    end

    initial begin
        reset_n = 1'b1;
        req     = 1'b0;
        addr    = '0;
        wr      = 1'b0;
        md      = 1'b0;
        inv     = 1'b0;
        model_reset();
        #3 reset_n = 1'b0;
        #1 check_zero("reset_initial");
        repeat (2) @(negedge clk);
        #1 reset_n = 1'b1;

        // Allocate tags 0,1,2 in set 0, then look up tag 1.
        issue(0, 0, 0, 1, 0, 0);
        issue(1, 0, 0, 1, 0, 0);
        issue(2, 0, 0, 1, 0, 0);
        issue(1, 0, 0, 0, 0, 0);
        // Fill set 0 with tags 0..7; tag 5 made dirty; LRU evictions.
        for (int t = 0; t < 8; t++) issue(t, 0, 0, 1, 0, 0);
        issue(5, 0, 7, 0, 1, 0);
        issue(8, 0, 0, 1, 0, 0);
        issue(9, 0, 0, 1, 0, 0);
        for (int t = 10; t < 16; t++) issue(t, 0, 0, 1, 0, 0);
        // Invalidate a valid line; the freed way is preferred next.
        issue(11, 0, 0, 0, 1, 1);
        issue(16, 0, 0, 1, 0, 0);
        issue(11, 0, 0, 0, 0, 0);
        // Same tag in two sets; back-to-back alloc then hit.
        issue(42, 1, 0, 1, 0, 0);
        issue(42, 2, 0, 1, 0, 0);
        issue(51, 3, 0, 1, 0, 0);
        issue(51, 3, 31, 0, 0, 0);
        issue(7, 0, 3, 0, 0, 0);
        issue(16, 0, 0, 0, 0, 0);
        idle();

        // Reset asserted while a request is on the inputs.
        @(negedge clk);
        #1;
        req  = 1'b1;
        addr = {7'd16, 2'd0, 5'd0};
        wr   = 1'b1;
        #3 reset_n = 1'b0;
        #1 check_zero("reset_mid_immediate");
        model_reset();
        @(negedge clk);
        check_zero("reset_mid_after_edge");
        #1;
        reset_n = 1'b1;
        req     = 1'b0;
        wr      = 1'b0;
        issue(16, 0, 0, 0, 0, 0);
        issue(16, 0, 0, 1, 0, 0);

        // Randomized traffic over a small tag range to mix hits and misses.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                issue(int'($urandom_range(0, 11)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 31)), bit'($urandom_range(0, 1)),
                      bit'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
            end
        end
        repeat (3) idle();

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
